dmem_ctrl: RTL and testbench



---
 rtl/dmem_ctrl_if.sv | 24 ++
 rtl/dmem_ctrl.sv | 187 ++++++++++++++++++
 tb/tb_dmem_ctrl.sv | 301 ++++++++++++++++++++++++++++++
 3 files changed

// File: rtl/dmem_ctrl_if.sv
// Request/response bus of the MEM-stage data memory controller.
// The requester uses the master modport, dmem_ctrl uses the slave modport.
interface dmem_ctrl_if;
   logic        req_valid;
   logic        req_ready;
   logic [3:0]  req_op;
   logic [31:0] req_addr;
   logic [31:0] req_wdata;
   logic        rsp_valid;
   logic        rsp_ready;
   logic [31:0] rsp_rdata;
   logic        rsp_fault;
   logic        rsp_is_write;

   modport master (
      output req_valid, req_op, req_addr, req_wdata, rsp_ready,
      input  req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_is_write
   );

   modport slave (
      input  req_valid, req_op, req_addr, req_wdata, rsp_ready,
      output req_ready, rsp_valid, rsp_rdata, rsp_fault, rsp_is_write
   );
endinterface

// File: rtl/dmem_ctrl.sv
// dmem_ctrl: handshaked, byte-addressed, little-endian data memory for the
// MEM stage. One access in flight; fixed access latency of LATENCY cycles
// from request accept to response valid; out-of-range accesses fault.
// Optional feature macro: DMEM_MISALIGN_TRAP_EN -- when defined, misaligned
// halfword/word accesses fault instead of executing byte-wise with wrap.
module dmem_ctrl #(
   parameter int ADDR_W  = 16,
   parameter int LATENCY = 1
) (
   input  logic        clock,
   input  logic        rst_n,
   dmem_ctrl_if.slave  bus
);

   localparam int DEPTH = 1 << ADDR_W;

   typedef enum logic [1:0] {
      IDLE = 2'd0,
      WAIT = 2'd1,
      RESP = 2'd2
   } state_t;

   state_t state, state_nxt;

   // captured request
   logic [3:0]  op_p0;
   logic [31:0] addr_p0;
   logic [31:0] wdata_p0;

   logic [3:0]  cnt;
   logic [31:0] rsp_rdata_q;
   logic        rsp_fault_q;
   logic        rsp_is_write_q;

   // Byte storage plus a per-byte "written since reset" flag; an unwritten
   // byte reads as zero, which gives an all-zero memory after every reset
   // without clearing the storage array itself.
   logic [7:0]       mem [DEPTH];
   logic [DEPTH-1:0] byte_valid;

   logic              accept;
   logic              execute;
   logic              req_ready_c;
   logic              rsp_valid_c;
   logic [ADDR_W-1:0] ba [4];
   logic [7:0]        rb [4];
   logic              is_half;
   logic              is_word;
   logic              range_fault;
   logic              misalign;
   logic              fault;
   logic              commit;
   logic [3:0]        wr_en;
   logic [31:0]       load_val;

   function automatic logic [31:0] sign_ext8(input logic signed [7:0] b);
      logic signed [31:0] w;
      w = 32'(b);
      return w;
   endfunction

   function automatic logic [31:0] sign_ext16(input logic signed [15:0] h);
      logic signed [31:0] w;
      w = 32'(h);
      return w;
   endfunction

   function automatic logic [31:0] zero_ext8(input logic [7:0] b);
      return 32'(b);
   endfunction

   function automatic logic [31:0] zero_ext16(input logic [15:0] h);
      return 32'(h);
   endfunction

   assign accept  = (state == IDLE) && bus.req_valid;
   assign execute = (state == WAIT) && (cnt == 4'd0);

   // State register
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) state <= IDLE;
      else        state <= state_nxt;
   end

   // Next-state and handshake outputs
   always_comb begin
      state_nxt   = state;
      req_ready_c = 1'b0;
      rsp_valid_c = 1'b0;
      unique case (state)
         IDLE: begin
            req_ready_c = 1'b1;
            if (bus.req_valid) state_nxt = WAIT;
         end
         WAIT: begin
            if (cnt == 4'd0) state_nxt = RESP;
         end
         RESP: begin
            rsp_valid_c = 1'b1;
            if (bus.rsp_ready) state_nxt = IDLE;
         end
         default: state_nxt = IDLE;
      endcase
   end

   // Capture the request on accept (pure data, no reset)
   always_ff @(posedge clock) begin
      if (accept) begin
         op_p0    <= bus.req_op;
         addr_p0  <= bus.req_addr;
         wdata_p0 <= bus.req_wdata;
      end
   end

   // Byte addresses, size decode, fault detection and load assembly
   always_comb begin
      for (int k = 0; k < 4; k++) begin
         ba[k] = addr_p0[ADDR_W-1:0] + ADDR_W'(k);
         rb[k] = byte_valid[ba[k]] ? mem[ba[k]] : 8'h00;
      end

      is_half = op_p0[3] ? (op_p0[1:0] == 2'd1)
                         : ((op_p0[2:0] == 3'd1) || (op_p0[2:0] == 3'd5));
      is_word = op_p0[3] ? op_p0[1]
                         : (op_p0[2:0] == 3'd2);

      range_fault = (addr_p0[31:ADDR_W] != '0);
`ifdef DMEM_MISALIGN_TRAP_EN
      misalign = (is_half && addr_p0[0]) || (is_word && (addr_p0[1:0] != 2'd0));
`else
      misalign = 1'b0;
`endif
      fault = range_fault || misalign;

      wr_en  = is_word ? 4'hF : (is_half ? 4'h3 : 4'h1);
      commit = execute && op_p0[3] && !fault;

      load_val = 32'h0;
      case (op_p0[2:0])
         3'd0:    load_val = sign_ext8(rb[0]);
         3'd1:    load_val = sign_ext16({rb[1], rb[0]});
         3'd2:    load_val = {rb[3], rb[2], rb[1], rb[0]};
         3'd4:    load_val = zero_ext8(rb[0]);
         3'd5:    load_val = zero_ext16({rb[1], rb[0]});
         default: load_val = 32'h0;
      endcase
   end

   // Latency counter, response registers and written-byte flags
   always_ff @(posedge clock or negedge rst_n) begin
      if (!rst_n) begin
         cnt            <= 4'd0;
         rsp_rdata_q    <= 32'h0;
         rsp_fault_q    <= 1'b0;
         rsp_is_write_q <= 1'b0;
         byte_valid     <= '0;
      end else begin
         if (accept) begin
            cnt <= 4'(LATENCY - 1);
         end else if ((state == WAIT) && (cnt != 4'd0)) begin
            cnt <= cnt - 4'd1;
         end
         if (execute) begin
            rsp_fault_q    <= fault;
            rsp_is_write_q <= op_p0[3];
            rsp_rdata_q    <= (fault || op_p0[3]) ? 32'h0 : load_val;
         end
         for (int k = 0; k < 4; k++) begin
            if (commit && wr_en[k]) byte_valid[ba[k]] <= 1'b1;
         end
      end
   end

   // Byte storage write port; reset never reaches the execute edge
   always_ff @(posedge clock) begin
      for (int k = 0; k < 4; k++) begin
         if (commit && wr_en[k]) mem[ba[k]] <= wdata_p0[8*k +: 8];
      end
   end

   assign bus.req_ready    = req_ready_c;
   assign bus.rsp_valid    = rsp_valid_c;
   assign bus.rsp_rdata    = rsp_rdata_q;
   assign bus.rsp_fault    = rsp_fault_q;
   assign bus.rsp_is_write = rsp_is_write_q;

endmodule

// File: tb/tb_dmem_ctrl.sv
// Self-checking bench for dmem_ctrl (ADDR_W=16, LATENCY=3). Expected
// responses are queued when a request is driven and compared when the
// response appears.
module tb_dmem_ctrl;
   localparam int ADDR_W  = 16;
   localparam int LATENCY = 3;

   typedef struct {
      logic [3:0]  op;
      logic [31:0] addr;
      logic [31:0] wdata;
      logic [31:0] rdata;
      logic        fault;
   } req_t;

   logic clock;
   logic rst_n;
   int   checks;
   int   failures;
   logic [33:0] exp_q[$];

   dmem_ctrl_if bus();

   dmem_ctrl #(.ADDR_W(ADDR_W), .LATENCY(LATENCY)) dut (
      .clock(clock),
      .rst_n(rst_n),
      .bus  (bus.slave)
   );

   initial clock = 1'b0;
   always #5 clock = ~clock;

   // Drive one request, push its expectation, wait for the response.
   task automatic run_one(input req_t r, output logic [31:0] rd, output logic f,
                          output logic w, output int lat, output logic ok,
                          output logic post);
      int n;
      ok = 1'b1;
      @(negedge clock);
      bus.req_op    = r.op;
      bus.req_addr  = r.addr;
      bus.req_wdata = r.wdata;
      bus.req_valid = 1'b1;
      exp_q.push_back({r.rdata, r.fault, r.op[3]});
      n = 0;
      while (!bus.req_ready && n < 40) begin
         @(negedge clock);
         n++;
      end
      if (!bus.req_ready) ok = 1'b0;
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      lat = 0;
      while (!bus.rsp_valid && lat < 40) begin
         @(posedge clock);
         #1;
         lat++;
      end
      if (!bus.rsp_valid) ok = 1'b0;
      rd = bus.rsp_rdata;
      f  = bus.rsp_fault;
      w  = bus.rsp_is_write;
      @(posedge clock);
      #1;
      post = bus.rsp_valid;
   endtask

   task automatic test_reset();
      rst_n         = 1'b0;
      bus.req_valid = 1'b0;
      bus.req_op    = 4'h0;
      bus.req_addr  = 32'h0;
      bus.req_wdata = 32'h0;
      bus.rsp_ready = 1'b1;
      repeat (3) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      @(negedge clock);
      checks++;
      if ({bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.rsp_is_write} !== 4'b1000) begin
         failures++;
         $display("FAIL reset_ctrl got rdy/vld/flt/wr=%b want 1000",
                  {bus.req_ready, bus.rsp_valid, bus.rsp_fault, bus.rsp_is_write});
      end
      checks++;
      if (bus.rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL reset_rdata got %h want 00000000", bus.rsp_rdata);
      end
   endtask

   task automatic test_access(input string name, input req_t tbl[$]);
      logic [31:0] rd;
      logic f, w, ok, post;
      int lat;
      logic [33:0] e;
      foreach (tbl[i]) begin
         run_one(tbl[i], rd, f, w, lat, ok, post);
         e = exp_q.pop_front();
         checks++;
         if (!ok || lat != LATENCY) begin
            failures++;
            $display("FAIL %s_lat[%0d] got %0d cycles ok=%b want %0d", name, i, lat, ok, LATENCY);
         end
         checks++;
         if ({rd, f, w} !== e) begin
            failures++;
            $display("FAIL %s_rsp[%0d] got rdata=%h fault=%b wr=%b want rdata=%h fault=%b wr=%b",
                     name, i, rd, f, w, e[33:2], e[1], e[0]);
         end
         checks++;
         if (post !== 1'b0) begin
            failures++;
            $display("FAIL %s_release[%0d] got rsp_valid=%b want 0", name, i, post);
         end
      end
   endtask

   task automatic test_backpressure();
      req_t r;
      logic [31:0] rd0;
      logic [33:0] e;
      int n;
      r = '{4'h5, 32'h12, 32'h0, 32'h0000_1234, 1'b0};
      bus.rsp_ready = 1'b0;
      @(negedge clock);
      bus.req_op = r.op; bus.req_addr = r.addr; bus.req_wdata = r.wdata;
      bus.req_valid = 1'b1;
      exp_q.push_back({r.rdata, r.fault, r.op[3]});
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      n = 0;
      while (!bus.rsp_valid && n < 40) begin
         @(posedge clock);
         #1;
         n++;
      end
      rd0 = bus.rsp_rdata;
      for (int c = 0; c < 5; c++) begin
         @(posedge clock);
         #1;
         checks++;
         if (bus.rsp_valid !== 1'b1 || bus.rsp_rdata !== rd0 || bus.req_ready !== 1'b0) begin
            failures++;
            $display("FAIL backpressure_hold[%0d] got vld=%b rdata=%h rdy=%b want vld=1 rdata=%h rdy=0",
                     c, bus.rsp_valid, bus.rsp_rdata, bus.req_ready, rd0);
         end
      end
      e = exp_q.pop_front();
      checks++;
      if ({bus.rsp_rdata, bus.rsp_fault, bus.rsp_is_write} !== e) begin
         failures++;
         $display("FAIL backpressure_rsp got rdata=%h fault=%b want rdata=%h fault=%b",
                  bus.rsp_rdata, bus.rsp_fault, e[33:2], e[1]);
      end
      @(negedge clock);
      bus.rsp_ready = 1'b1;
      @(posedge clock);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1) begin
         failures++;
         $display("FAIL backpressure_release got vld=%b rdy=%b want vld=0 rdy=1",
                  bus.rsp_valid, bus.req_ready);
      end
   endtask

   task automatic test_back_to_back();
      int n_acc, n_rsp, c;
      logic [33:0] e;
      bus.rsp_ready = 1'b1;
      @(negedge clock);
      bus.req_op = 4'h2; bus.req_addr = 32'h10; bus.req_wdata = 32'h0;
      bus.req_valid = 1'b1;
      n_acc = 0; n_rsp = 0; c = 0;
      while (n_rsp < 3 && c < 60) begin
         if (bus.rsp_valid && bus.rsp_ready) begin
            e = exp_q.pop_front();
            n_rsp++;
            checks++;
            if ({bus.rsp_rdata, bus.rsp_fault, bus.rsp_is_write} !== e) begin
               failures++;
               $display("FAIL b2b_rsp[%0d] got rdata=%h fault=%b want rdata=%h fault=%b",
                        n_rsp, bus.rsp_rdata, bus.rsp_fault, e[33:2], e[1]);
            end
         end
         if (bus.req_valid && bus.req_ready) begin
            exp_q.push_back({32'h1234_AB13, 1'b0, 1'b0});
            n_acc++;
         end else if (n_acc == 3) begin
            bus.req_valid = 1'b0;
         end
         @(negedge clock);
         c++;
      end
      bus.req_valid = 1'b0;
      checks++;
      if (n_rsp != 3 || n_acc != 3) begin
         failures++;
         $display("FAIL b2b_count got acc=%0d rsp=%0d want 3/3", n_acc, n_rsp);
      end
   endtask

   task automatic test_reset_abort();
      int n;
      req_t t[$];
      @(negedge clock);
      bus.req_op = 4'hA; bus.req_addr = 32'h20; bus.req_wdata = 32'hDEAD_BEEF;
      bus.req_valid = 1'b1;
      n = 0;
      while (!bus.req_ready && n < 40) begin
         @(negedge clock);
         n++;
      end
      @(posedge clock);
      #1;
      bus.req_valid = 1'b0;
      @(posedge clock);
      #1;
      rst_n = 1'b0;
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0 || bus.req_ready !== 1'b1 || bus.rsp_rdata !== 32'h0) begin
         failures++;
         $display("FAIL abort_reset got vld=%b rdy=%b rdata=%h want vld=0 rdy=1 rdata=0",
                  bus.rsp_valid, bus.req_ready, bus.rsp_rdata);
      end
      repeat (2) @(posedge clock);
      @(negedge clock);
      rst_n = 1'b1;
      repeat (LATENCY + 2) @(posedge clock);
      #1;
      checks++;
      if (bus.rsp_valid !== 1'b0) begin
         failures++;
         $display("FAIL abort_no_rsp got rsp_valid=%b want 0", bus.rsp_valid);
      end
      t = '{'{4'h2, 32'h20, 32'h0, 32'h0, 1'b0},
            '{4'h2, 32'h10, 32'h0, 32'h0, 1'b0}};
      test_access("abort_readback", t);
   endtask

   initial begin
      req_t t[$];
      checks   = 0;
      failures = 0;
      test_reset();

      t = '{'{4'hA, 32'h10, 32'h8000_0013, 32'h0, 1'b0},
            '{4'h2, 32'h10, 32'h0, 32'h8000_0013, 1'b0}};
      test_access("store_load", t);

      t = '{'{4'h0, 32'h10, 32'h0, 32'h0000_0013, 1'b0},
            '{4'h0, 32'h13, 32'h0, 32'hFFFF_FF80, 1'b0},
            '{4'h4, 32'h13, 32'h0, 32'h0000_0080, 1'b0},
            '{4'h1, 32'h12, 32'h0, 32'hFFFF_8000, 1'b0},
            '{4'h5, 32'h12, 32'h0, 32'h0000_8000, 1'b0},
            '{4'h3, 32'h10, 32'h0, 32'h0, 1'b0}};
      test_access("byte_half", t);

      t = '{'{4'h8, 32'h11, 32'h0000_00AB, 32'h0, 1'b0},
            '{4'h2, 32'h10, 32'h0, 32'h8000_AB13, 1'b0},
            '{4'h9, 32'h12, 32'h0000_1234, 32'h0, 1'b0},
            '{4'h2, 32'h10, 32'h0, 32'h1234_AB13, 1'b0}};
      test_access("partial_store", t);

      t = '{'{4'hA, 32'h0001_0000, 32'hFFFF_FFFF, 32'h0, 1'b1},
            '{4'h2, 32'h0000_0000, 32'h0, 32'h0, 1'b0},
            '{4'h2, 32'h8000_0010, 32'h0, 32'h0, 1'b1}};
      test_access("range", t);

      t = '{'{4'h8, 32'hFFFE, 32'h11, 32'h0, 1'b0},
            '{4'h8, 32'hFFFF, 32'h22, 32'h0, 1'b0},
            '{4'h8, 32'h0000, 32'h33, 32'h0, 1'b0},
            '{4'h8, 32'h0001, 32'h44, 32'h0, 1'b0},
`ifdef DMEM_MISALIGN_TRAP_EN
            '{4'h2, 32'hFFFE, 32'h0, 32'h0, 1'b1},
            '{4'h1, 32'hFFFF, 32'h0, 32'h0, 1'b1}};
`else
            '{4'h2, 32'hFFFE, 32'h0, 32'h4433_2211, 1'b0},
            '{4'h1, 32'hFFFF, 32'h0, 32'h0000_3322, 1'b0}};
`endif
      test_access("misalign", t);

      test_backpressure();
      test_back_to_back();
      test_reset_abort();

      $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
      $finish;
   end

   // Global watchdog so the run always ends
   initial begin
      #200000;
      $display("FAIL watchdog got timeout want completion");
      $fatal(1, "watchdog");
   end
endmodule
